// File: rtl/dcs_stream_feeder.sv
// dcs_stream_feeder: host-side feeder for the DCSformer accelerator.
// Host words go into one of two word FIFOs. The input FIFO is sent out
// as fixed-length byte bursts with no backpressure. The weight FIFO is
// sent out as a byte stream under a valid/ready handshake. Accelerator
// results are registered back to the host and counted.
//
// Handshake semantics (host side and weight side): a transfer happens on
// a rising edge where valid && ready. The sender holds valid and its data
// stable until that edge. The receiver may change ready freely, and ready
// never depends combinationally on the same channel's valid.

// Word FIFO with registered occupancy count and a combinational head word.
module dcs_word_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [31:0]            wdata,
    input  logic                   pop,
    output logic [31:0]            head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointer and occupancy bookkeeping; reset discards all buffered words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Word storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// Top level: two FIFOs, the input burst serializer, the weight handshake
// serializer and the result register/counter.
module dcs_stream_feeder #(
    parameter int FIFO_DEPTH    = 4,
    parameter int I_BURST_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_ch,
    input  logic [31:0] s_data,
    output logic        i_valid,
    output logic [7:0]  i_data,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [7:0]  w_data,
    input  logic        o_valid,
    input  logic [31:0] o_data,
    output logic        r_valid,
    output logic [31:0] r_data,
    output logic [15:0] res_cnt
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int BCW = $clog2(4 * I_BURST_WORDS);
    localparam logic [BCW-1:0] I_LAST_BYTE = BCW'(4 * I_BURST_WORDS - 1);

    typedef enum logic { I_IDLE, I_BURST } i_state_t;
    typedef enum logic { W_IDLE, W_SEND  } w_state_t;

    // FIFO connections
    logic          push_i, push_w;
    logic          i_pop, w_pop;
    logic [31:0]   i_head, w_head;
    logic [CW-1:0] i_count, w_count;
    logic          i_full, w_full;
    logic          i_empty, w_empty;

    // Input serializer
    i_state_t       i_state, i_state_nxt;
    logic [1:0]     i_byte_idx;
    logic [BCW-1:0] i_byte_cnt;
    logic           i_last;

    // Weight serializer
    w_state_t      w_state, w_state_nxt;
    logic [1:0]    w_byte_idx;
    logic          w_load;
    logic          w_valid_nxt;
    logic [CW-1:0] w_count_nxt;

    // Host write: ready reflects the pre-edge count of the selected FIFO.
    assign s_ready = s_ch ? !w_full : !i_full;
    assign push_i  = s_valid && s_ready && !s_ch;
    assign push_w  = s_valid && s_ready &&  s_ch;

    dcs_word_fifo #(.DEPTH(FIFO_DEPTH)) u_i_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_i),
        .wdata (s_data),
        .pop   (i_pop),
        .head  (i_head),
        .count (i_count),
        .full  (i_full),
        .empty (i_empty)
    );

    dcs_word_fifo #(.DEPTH(FIFO_DEPTH)) u_w_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_w),
        .wdata (s_data),
        .pop   (w_pop),
        .head  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Input FSM next state: start only on a full burst, and always leave
    // at least one idle cycle between bursts.
    always_comb begin
        i_state_nxt = i_state;
        i_pop       = 1'b0;
        i_last      = (i_byte_cnt == I_LAST_BYTE);
        case (i_state)
            I_IDLE: begin
                if (i_count >= CW'(I_BURST_WORDS)) i_state_nxt = I_BURST;
            end
            I_BURST: begin
                i_pop = (i_byte_idx == 2'd3);
                if (i_last) i_state_nxt = I_IDLE;
            end
            default: i_state_nxt = I_IDLE;
        endcase
    end

    // Input FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) i_state <= I_IDLE;
        else        i_state <= i_state_nxt;
    end

    // Input byte output register: one byte per burst cycle, low byte first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_valid    <= 1'b0;
            i_data     <= '0;
            i_byte_idx <= '0;
            i_byte_cnt <= '0;
        end else begin
            i_valid <= (i_state == I_BURST);
            if (i_state == I_BURST) begin
                i_data     <= i_head[{i_byte_idx, 3'b000} +: 8];
                i_byte_idx <= i_byte_idx + 1'b1;
                i_byte_cnt <= i_last ? '0 : i_byte_cnt + 1'b1;
            end else begin
                i_byte_idx <= '0;
                i_byte_cnt <= '0;
            end
        end
    end

    // Weight FSM next state and output-register load. The output register
    // takes a new byte whenever it is empty or its byte is being accepted,
    // which gives one byte per cycle across word boundaries. W_SEND is held
    // until both the FIFO and the output register have drained.
    always_comb begin
        w_state_nxt = w_state;
        w_load      = (w_state == W_SEND) && !w_empty && (!w_valid || w_ready);
        w_pop       = w_load && (w_byte_idx == 2'd3);
        w_valid_nxt = w_valid;
        if (w_load)       w_valid_nxt = 1'b1;
        else if (w_ready) w_valid_nxt = 1'b0;
        w_count_nxt = w_count;
        if (push_w && !w_pop)      w_count_nxt = w_count + 1'b1;
        else if (!push_w && w_pop) w_count_nxt = w_count - 1'b1;
        case (w_state)
            W_IDLE: begin
                if (!w_empty) w_state_nxt = W_SEND;
            end
            W_SEND: begin
                if (w_count_nxt == '0 && !w_valid_nxt) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Weight FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    // Weight byte output register; data only changes on a load, so it holds during stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_valid    <= 1'b0;
            w_data     <= '0;
            w_byte_idx <= '0;
        end else begin
            w_valid <= w_valid_nxt;
            if (w_load) begin
                w_data     <= w_head[{w_byte_idx, 3'b000} +: 8];
                w_byte_idx <= w_byte_idx + 1'b1;
            end
        end
    end

    // Result register and wrapping result counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            res_cnt <= '0;
        end else begin
            r_valid <= o_valid;
            if (o_valid) begin
                r_data  <= o_data;
                res_cnt <= res_cnt + 16'd1;
            end
        end
    end
endmodule
